param_sync_fifo: RTL and testbench

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_mem.sv | 28 ++
 rtl/param_sync_fifo.sv | 125 ++++++++++++
 tb/tb_param_sync_fifo.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and the read-mode encoding for the synchronous FIFO.
package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 4;

    // Read-port behaviour: data falls through to the output, or is registered on a read.
    typedef enum logic {
        READ_STANDARD = 1'b0,
        READ_FWFT     = 1'b1
    } read_mode_e;

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write port, asynchronous read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Store the incoming word on an accepted write.
    // NOTE: the array has no reset; occupancy is tracked by the pointers, so stale words are never observed as valid data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : fifo_mem

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/empty flags, sticky
// overflow/underflow errors, synchronous flush and selectable read mode.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
    parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 4,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_winc,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_rinc,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_wfull,
    output logic                  o_afull,
    output logic                  o_rempty,
    output logic                  o_aempty,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;
    localparam read_mode_e READ_MODE = (FWFT != 0) ? READ_FWFT : READ_STANDARD;

    localparam logic [PW-1:0] FULL_CNT   = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_CNT  = PW'(AFULL_THRESH);
    localparam logic [PW-1:0] AEMPTY_CNT = PW'(AEMPTY_THRESH);

    // Thresholds must be ordered and fit inside the buffer.
    generate
        if (AEMPTY_THRESH < 0 || AEMPTY_THRESH >= AFULL_THRESH || AFULL_THRESH > DEPTH) begin : g_bad_thresh
            $error("param_sync_fifo: need 0 <= AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
        end
    endgenerate

    // One extra MSB per pointer distinguishes full from empty when low bits match.
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [PW-1:0]         count;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Flags depend only on the registered count, never on this cycle's requests.
    assign o_wfull  = (count == FULL_CNT);
    assign o_rempty = (count == '0);
    assign o_afull  = (count >= AFULL_CNT);
    assign o_aempty = (count <= AEMPTY_CNT);
    assign o_count  = count;

    // A flush blocks both ports; a full FIFO refuses writes even if a read frees a slot.
    assign wr_en = i_winc && !o_wfull  && !i_flush;
    assign rd_en = i_rinc && !o_rempty && !i_flush;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (i_clk),
        .we    (wr_en),
        .waddr (wptr[ADDR_WIDTH-1:0]),
        .wdata (i_wdata),
        .raddr (rptr[ADDR_WIDTH-1:0]),
        .rdata (mem_rdata)
    );

    // Advance pointers and occupancy on accepted transfers; flush returns to empty.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (i_flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_en) wptr <= wptr + PW'(1);
            if (rd_en) rptr <= rptr + PW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + PW'(1);
                2'b01:   count <= count - PW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags record any request made against a full or empty FIFO.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else if (i_flush) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (i_winc && o_wfull)  o_overflow  <= 1'b1;
            if (i_rinc && o_rempty) o_underflow <= 1'b1;
        end
    end

    generate
        if (READ_MODE == READ_FWFT) begin : g_fwft
            assign o_rdata = mem_rdata;
        end else begin : g_std
            // Capture the head word on an accepted read and hold it otherwise.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    o_rdata <= '0;
                end else if (rd_en) begin
                    o_rdata <= mem_rdata;
                end
            end
        end
    endgenerate

endmodule : param_sync_fifo

// File: tb/tb_param_sync_fifo.sv
// Directed bench: a queue-based occupancy model is compared against the FWFT and
// standard-read builds every cycle, alongside hand-computed literal expectations.
module tb_param_sync_fifo;

    localparam int DEPTH = 16;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       flush = 1'b0;
    logic       winc  = 1'b0;
    logic       rinc  = 1'b0;
    logic [7:0] wdata = 8'h00;

    logic [7:0] f_rdata, s_rdata;
    logic       f_wfull, f_afull, f_rempty, f_aempty, f_ovf, f_unf;
    logic       s_wfull, s_afull, s_rempty, s_aempty, s_ovf, s_unf;
    logic [4:0] f_count, s_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    param_sync_fifo #(
        .DATA_WIDTH (8), .ADDR_WIDTH (4), .AFULL_THRESH (12), .AEMPTY_THRESH (2), .FWFT (1)
    ) dut (
        .i_clk (clk), .i_rst (rst), .i_flush (flush), .i_winc (winc), .i_wdata (wdata),
        .i_rinc (rinc), .o_rdata (f_rdata), .o_wfull (f_wfull), .o_afull (f_afull),
        .o_rempty (f_rempty), .o_aempty (f_aempty), .o_count (f_count),
        .o_overflow (f_ovf), .o_underflow (f_unf)
    );

    param_sync_fifo #(
        .DATA_WIDTH (8), .ADDR_WIDTH (4), .AFULL_THRESH (12), .AEMPTY_THRESH (2), .FWFT (0)
    ) dut_std (
        .i_clk (clk), .i_rst (rst), .i_flush (flush), .i_winc (winc), .i_wdata (wdata),
        .i_rinc (rinc), .o_rdata (s_rdata), .o_wfull (s_wfull), .o_afull (s_afull),
        .o_rempty (s_rempty), .o_aempty (s_aempty), .o_count (s_count),
        .o_overflow (s_ovf), .o_underflow (s_unf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: contents as an ordered queue, flags from its size.
    logic [7:0] mq [$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;
    logic [7:0] m_std = 8'h00;

    always @(posedge clk or posedge rst) begin : model
        int sz;
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_std = 8'h00;
        end else if (flush) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            sz = mq.size();
            if (winc && sz == DEPTH) m_ovf = 1'b1;
            if (rinc && sz == 0)     m_unf = 1'b1;
            if (rinc && sz > 0)      m_std = mq.pop_front();
            if (winc && sz < DEPTH)  mq.push_back(wdata);
        end
    end

    // Every cycle, compare both builds against the model away from the rising edge.
    always @(negedge clk) begin : monitor
        int sz;
        sz = mq.size();
        check("count",     32'(f_count),  32'(sz));
        check("wfull",     32'(f_wfull),  32'(sz == DEPTH));
        check("rempty",    32'(f_rempty), 32'(sz == 0));
        check("afull",     32'(f_afull),  32'(sz >= 12));
        check("aempty",    32'(f_aempty), 32'(sz <= 2));
        check("overflow",  32'(f_ovf),    32'(m_ovf));
        check("underflow", 32'(f_unf),    32'(m_unf));
        check("std_count", 32'(s_count),  32'(sz));
        check("std_flags", 32'({s_wfull, s_afull, s_rempty, s_aempty, s_ovf, s_unf}),
              32'({sz == DEPTH, sz >= 12, sz == 0, sz <= 2, m_ovf, m_unf}));
        check("std_rdata", 32'(s_rdata),  32'(m_std));
        if (sz > 0) check("fwft_rdata", 32'(f_rdata), 32'(mq[0]));
    end

    // Apply one cycle of inputs, then return just after the rising edge.
    task automatic tick(input logic w, input logic [7:0] d, input logic r, input logic f);
        winc  = w;
        wdata = d;
        rinc  = r;
        flush = f;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_to_overflow_then_seven(input logic [7:0] base);
        for (int i = 0; i < 16; i++) tick(1'b1, base + 8'(i), 1'b0, 1'b0);
        tick(1'b1, 8'hAA, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) tick(1'b0, 8'h00, 1'b1, 1'b0);
        check("lit_count7", 32'(f_count), 32'd7);
        check("lit_ovf_set", 32'(f_ovf), 32'd1);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        check("rst_rempty", 32'(f_rempty), 32'd1);
        check("rst_aempty", 32'(f_aempty), 32'd1);
        check("rst_wfull",  32'(f_wfull),  32'd0);
        check("rst_afull",  32'(f_afull),  32'd0);
        check("rst_count",  32'(f_count),  32'd0);
        check("rst_std_rdata", 32'(s_rdata), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;

        // Fill 0x00..0x0F, then drain in order.
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, 8'(i), 1'b0, 1'b0);
            check("fill_count", 32'(f_count), 32'(i + 1));
            check("fill_afull", 32'(f_afull), 32'(i + 1 >= 12));
            check("fill_wfull", 32'(f_wfull), 32'(i + 1 == 16));
            if (i == 0) check("first_word", 32'(f_rdata), 32'h00);
        end
        for (int i = 0; i < 16; i++) begin
            check("drain_fwft", 32'(f_rdata), 32'(i));
            if (i > 0) check("std_hold", 32'(s_rdata), 32'(i - 1));
            tick(1'b0, 8'h00, 1'b1, 1'b0);
            check("std_next", 32'(s_rdata), 32'(i));
        end
        check("drained_empty", 32'(f_rempty), 32'd1);

        // Overflow, simultaneous access at full, drain, access at empty, underflow.
        for (int i = 0; i < 16; i++) tick(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
        tick(1'b1, 8'hAA, 1'b0, 1'b0);
        check("ovf_count", 32'(f_count), 32'd16);
        check("ovf_flag",  32'(f_ovf),   32'd1);
        check("ovf_head",  32'(f_rdata), 32'h20);
        tick(1'b1, 8'hBB, 1'b1, 1'b0);
        check("full_rw_count", 32'(f_count), 32'd15);
        for (int i = 1; i < 16; i++) begin
            check("drain2", 32'(f_rdata), 32'h20 + 32'(i));
            tick(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("drain2_count", 32'(f_count), 32'd0);
        tick(1'b1, 8'h77, 1'b1, 1'b0);
        check("empty_rw_count", 32'(f_count), 32'd1);
        check("empty_rw_unf",   32'(f_unf),   32'd1);
        check("empty_rw_data",  32'(f_rdata), 32'h77);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        check("std_77", 32'(s_rdata), 32'h77);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        check("unf_count", 32'(f_count), 32'd0);
        check("unf_flag",  32'(f_unf),   32'd1);

        // Simultaneous access at count 5.
        for (int i = 0; i < 5; i++) tick(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
        tick(1'b1, 8'h45, 1'b1, 1'b0);
        check("mid_rw_count", 32'(f_count), 32'd5);
        check("mid_rw_std",   32'(s_rdata), 32'h40);

        // Flush together with a write at count 7 with overflow set.
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        check("flush_clr_unf", 32'(f_unf), 32'd0);
        fill_to_overflow_then_seven(8'h60);
        tick(1'b1, 8'hCC, 1'b0, 1'b1);
        check("flush_count",  32'(f_count),  32'd0);
        check("flush_rempty", 32'(f_rempty), 32'd1);
        check("flush_ovf",    32'(f_ovf),    32'd0);
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        check("flush_no_write", 32'(f_count), 32'd0);

        // Asynchronous reset in the middle of a write burst.
        fill_to_overflow_then_seven(8'h80);
        winc  = 1'b1;
        wdata = 8'hDD;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_count",  32'(f_count),  32'd0);
        check("arst_rempty", 32'(f_rempty), 32'd1);
        check("arst_ovf",    32'(f_ovf),    32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        tick(1'b1, 8'h5A, 1'b0, 1'b0);
        check("post_rst_count", 32'(f_count), 32'd1);
        check("fwft_5a",        32'(f_rdata), 32'h5A);

        // Stream 40 words at constant occupancy 3, crossing the index wrap.
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) tick(1'b1, 8'h10 + 8'(k), 1'b0, 1'b0);
        for (int k = 3; k < 40; k++) begin
            check("wrap_head", 32'(f_rdata), 32'h10 + 32'(k - 3));
            tick(1'b1, 8'h10 + 8'(k), 1'b1, 1'b0);
            check("wrap_count", 32'(f_count), 32'd3);
        end
        for (int k = 37; k < 40; k++) begin
            check("wrap_tail", 32'(f_rdata), 32'h10 + 32'(k));
            tick(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("wrap_ovf",    32'(f_ovf),    32'd0);
        check("wrap_unf",    32'(f_unf),    32'd0);
        check("wrap_empty",  32'(f_rempty), 32'd1);
        check("wrap_std_37", 32'(s_rdata),  32'h37);

        tick(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_param_sync_fifo
